// File: rtl/brick_pkg.sv
// Shared types and colour map for the Breakout brick field.
package brick_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FULL_DRAW,
        ST_IDLE,
        ST_CHECK,
        ST_REDRAW
    } state_t;

    typedef logic [2:0] colour_t;

    localparam colour_t COL_BG   = 3'b111;
    localparam colour_t COL_H1   = 3'b110;
    localparam colour_t COL_H2   = 3'b010;
    localparam colour_t COL_H3   = 3'b001;
    localparam colour_t COL_H4   = 3'b100;
    localparam colour_t COL_HIGH = 3'b101;

    // Dead bricks are painted in the background colour so a redraw erases them.
    function automatic colour_t health_colour(input logic [2:0] h);
        case (h)
            3'd0:    return COL_BG;
            3'd1:    return COL_H1;
            3'd2:    return COL_H2;
            3'd3:    return COL_H3;
            3'd4:    return COL_H4;
            default: return COL_HIGH;
        endcase
    endfunction

endpackage

// File: rtl/brick_field_if.sv
// Pixel stream from the brick field to the VGA plotter (valid/ready).
interface brick_field_if #(
    parameter int COORD_W = 8
);
    import brick_pkg::*;

    logic               PLOT;
    logic               DRAW_READY;
    logic [COORD_W-1:0] XOUT;
    logic [COORD_W-1:0] YOUT;
    colour_t            COLOUR;

    modport master (output PLOT, XOUT, YOUT, COLOUR, input DRAW_READY);
    modport slave  (input PLOT, XOUT, YOUT, COLOUR, output DRAW_READY);

endinterface

// File: rtl/brick_pixel_scan.sv
// Row-major pixel walker over one brick; advances only on an accepted pixel.
module brick_pixel_scan #(
    parameter  int BRICK_W = 16,
    parameter  int BRICK_H = 8,
    localparam int PX_W    = (BRICK_W > 1) ? $clog2(BRICK_W) : 1,
    localparam int PY_W    = (BRICK_H > 1) ? $clog2(BRICK_H) : 1
) (
    input  logic            CLOCK_50,
    input  logic            RESETN,
    input  logic            i_clear,
    input  logic            i_advance,
    output logic [PX_W-1:0] o_px,
    output logic [PY_W-1:0] o_py,
    output logic            o_last
);

    logic [PX_W-1:0] r_px;
    logic [PY_W-1:0] r_py;
    logic            w_px_end;
    logic            w_py_end;

    assign w_px_end = (r_px == PX_W'(BRICK_W - 1));
    assign w_py_end = (r_py == PY_W'(BRICK_H - 1));

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_clear) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_advance) begin
            if (w_px_end) begin
                r_px <= '0;
                r_py <= w_py_end ? '0 : r_py + PY_W'(1);
            end else begin
                r_px <= r_px + PX_W'(1);
            end
        end
    end

    assign o_px   = r_px;
    assign o_py   = r_py;
    assign o_last = w_px_end && w_py_end;

endmodule

// File: rtl/brick_field.sv
// Parametrised Breakout brick field: health store, sequential hit search and
// pixel streaming of full-field and single-brick redraws.
module brick_field
    import brick_pkg::*;
#(
    parameter  int COLS       = 8,
    parameter  int ROWS       = 4,
    parameter  int BRICK_W    = 16,
    parameter  int BRICK_H    = 8,
    parameter  int PITCH_X    = 20,
    parameter  int PITCH_Y    = 12,
    parameter  int ANCHOR_X   = 2,
    parameter  int ANCHOR_Y   = 4,
    parameter  int MAX_HEALTH = 4,
    parameter  int COORD_W    = 8,
    localparam int N          = ROWS * COLS,
    localparam int BL_W       = $clog2(N + 1)
) (
    input  logic               CLOCK_50,
    input  logic               RESETN,
    input  logic               LEVEL_LOAD,
    input  logic [COORD_W-1:0] BALL_X,
    input  logic [COORD_W-1:0] BALL_Y,
    input  logic               HIT_REQ,
    output logic               BUSY,
    output logic               HIT_DONE,
    output logic               HIT,
    brick_field_if.master      draw,
    output logic [BL_W-1:0]    BRICKS_LEFT,
    output logic               LEVEL_CLEAR
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PX_W  = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
    localparam int PY_W  = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;

    state_t             r_state, w_next;
    logic [COL_W-1:0]   r_col, w_col_step;
    logic [ROW_W-1:0]   r_row, w_row_step;
    logic [2:0]         r_health [N];
    logic [COORD_W-1:0] r_qx, r_qy;
    logic [BL_W-1:0]    r_left;
    logic               r_clear, r_hit_done, r_hit;

    logic [IDX_W-1:0]   w_idx;
    logic [2:0]         w_cur_h;
    logic [31:0]        w_bx, w_by;
    logic [PX_W-1:0]    w_px;
    logic [PY_W-1:0]    w_py;
    logic               w_last_px, w_last_brick, w_plot, w_accept, w_match;

    brick_pixel_scan #(
        .BRICK_W (BRICK_W),
        .BRICK_H (BRICK_H)
    ) u_scan (
        .CLOCK_50  (CLOCK_50),
        .RESETN    (RESETN),
        .i_clear   (r_state == ST_INIT),
        .i_advance (w_accept),
        .o_px      (w_px),
        .o_py      (w_py),
        .o_last    (w_last_px)
    );

    assign w_idx        = IDX_W'(32'(r_row) * 32'(COLS) + 32'(r_col));
    assign w_cur_h      = r_health[w_idx];
    assign w_bx         = ANCHOR_X + PITCH_X * 32'(r_col);
    assign w_by         = ANCHOR_Y + PITCH_Y * 32'(r_row);
    assign w_last_brick = (r_col == COL_W'(COLS - 1)) && (r_row == ROW_W'(ROWS - 1));
    assign w_accept     = w_plot && draw.DRAW_READY;
    assign w_col_step   = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
    assign w_row_step   = (r_col == COL_W'(COLS - 1)) ? r_row + ROW_W'(1) : r_row;

    assign w_match = (r_state == ST_CHECK) && (w_cur_h != '0)
                  && (32'(r_qx) >= w_bx) && (32'(r_qx) < w_bx + 32'(BRICK_W))
                  && (32'(r_qy) >= w_by) && (32'(r_qy) < w_by + 32'(BRICK_H));

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) r_state <= ST_INIT;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        BUSY   = (r_state != ST_IDLE);
        w_plot = (r_state == ST_FULL_DRAW) || (r_state == ST_REDRAW);
        if (LEVEL_LOAD) begin
            w_next = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:      w_next = ST_FULL_DRAW;
                ST_FULL_DRAW: if (w_accept && w_last_px && w_last_brick) w_next = ST_IDLE;
                ST_IDLE:      if (HIT_REQ) w_next = ST_CHECK;
                ST_CHECK: begin
                    if (w_match)           w_next = ST_REDRAW;
                    else if (w_last_brick) w_next = ST_IDLE;
                end
                ST_REDRAW:    if (w_accept && w_last_px) w_next = ST_IDLE;
                default:      w_next = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < N; i++) r_health[i] <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_qx       <= '0;
            r_qy       <= '0;
            r_left     <= '0;
            r_clear    <= 1'b0;
            r_hit_done <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            r_hit_done <= 1'b0;
            r_hit      <= 1'b0;
            if (LEVEL_LOAD) begin
                r_col <= '0;
                r_row <= '0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        for (int unsigned i = 0; i < N; i++)
                            r_health[i] <= 3'(MAX_HEALTH - (i / COLS) % MAX_HEALTH);
                        r_left  <= BL_W'(N);
                        r_clear <= 1'b0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                    ST_FULL_DRAW: begin
                        if (w_accept && w_last_px && !w_last_brick) begin
                            r_col <= w_col_step;
                            r_row <= w_row_step;
                        end
                    end
                    ST_IDLE: begin
                        if (HIT_REQ) begin
                            r_qx  <= BALL_X;
                            r_qy  <= BALL_Y;
                            r_col <= '0;
                            r_row <= '0;
                        end
                    end
                    ST_CHECK: begin
                        // On a hit the brick position is kept so REDRAW paints that brick.
                        if (w_match) begin
                            r_health[w_idx] <= w_cur_h - 3'(1);
                            if (w_cur_h == 3'(1)) begin
                                r_left <= r_left - BL_W'(1);
                                if (r_left == BL_W'(1)) r_clear <= 1'b1;
                            end
                            r_hit_done <= 1'b1;
                            r_hit      <= 1'b1;
                        end else if (w_last_brick) begin
                            r_hit_done <= 1'b1;
                            r_col      <= '0;
                            r_row      <= '0;
                        end else begin
                            r_col <= w_col_step;
                            r_row <= w_row_step;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        draw.PLOT   = w_plot;
        draw.XOUT   = '0;
        draw.YOUT   = '0;
        draw.COLOUR = '0;
        if (w_plot) begin
            draw.XOUT   = COORD_W'(w_bx + 32'(w_px));
            draw.YOUT   = COORD_W'(w_by + 32'(w_py));
            draw.COLOUR = health_colour(w_cur_h);
        end
    end

    assign HIT_DONE    = r_hit_done;
    assign HIT         = r_hit;
    assign BRICKS_LEFT = r_left;
    assign LEVEL_CLEAR = r_clear;

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: vector table, randomized hit queries
// against a geometric reference model, and abort/reset sequences.
module tb_brick_field;

    localparam int COLS = 8,  ROWS = 4,  N = 32;
    localparam int BW   = 16, BH   = 8,  PX = 20, PY = 12;
    localparam int AX   = 2,  AY   = 4,  MAXH = 4, CW = 8;
    localparam int NPIX = BW * BH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          level_load = 1'b0;
    logic          hit_req = 1'b0;
    logic [CW-1:0] ball_x = '0, ball_y = '0;
    logic          busy, hit_done, hit, level_clear;
    logic [5:0]    bricks_left;

    brick_field_if #(.COORD_W(CW)) draw_if ();

    brick_field #(
        .COLS(COLS), .ROWS(ROWS), .BRICK_W(BW), .BRICK_H(BH),
        .PITCH_X(PX), .PITCH_Y(PY), .ANCHOR_X(AX), .ANCHOR_Y(AY),
        .MAX_HEALTH(MAXH), .COORD_W(CW)
    ) dut (
        .CLOCK_50(clk), .RESETN(rstn), .LEVEL_LOAD(level_load),
        .BALL_X(ball_x), .BALL_Y(ball_y), .HIT_REQ(hit_req),
        .BUSY(busy), .HIT_DONE(hit_done), .HIT(hit),
        .draw(draw_if), .BRICKS_LEFT(bricks_left), .LEVEL_CLEAR(level_clear)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int mh [N];
    int m_left, m_clear;
    int first_x, first_y, first_c, last_x, last_y, last_c;

    typedef struct {
        int x; int y; int exp_hit; int exp_idx; int exp_colour; int exp_left; bit toggle;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_colour(input int h);
        case (h)
            0: return 7;
            1: return 6;
            2: return 2;
            3: return 1;
            4: return 4;
            default: return 5;
        endcase
    endfunction

    // Geometric lookup: which live brick (if any) covers the point.
    function automatic int model_find(input int x, input int y);
        int c, r, ox, oy;
        if (x < AX || y < AY) return -1;
        c = (x - AX) / PX;  ox = (x - AX) % PX;
        r = (y - AY) / PY;  oy = (y - AY) % PY;
        if (c >= COLS || r >= ROWS || ox >= BW || oy >= BH) return -1;
        if (mh[r * COLS + c] == 0) return -1;
        return r * COLS + c;
    endfunction

    task automatic model_reload();
        for (int i = 0; i < N; i++) mh[i] = MAXH - ((i / COLS) % MAXH);
        m_left  = N;
        m_clear = 0;
    endtask

    // Consume nbricks consecutive bricks of pixels starting at b0, checking each
    // accepted pixel and that outputs hold across stalled cycles.
    task automatic collect(input int b0, input int nbricks, input bit toggle);
        int k, cyc, bad, total, b, p, ex, ey, ec, hx, hy, hc, limit;
        bit held_v;
        total  = nbricks * NPIX;
        limit  = total * 3 + 50;
        k = 0; cyc = 0; bad = 0; held_v = 0;
        hx = 0; hy = 0; hc = 0;
        while (k < total && cyc < limit) begin
            draw_if.DRAW_READY = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (held_v) begin
                if (draw_if.PLOT !== 1'b1 || int'(draw_if.XOUT) != hx ||
                    int'(draw_if.YOUT) != hy || int'(draw_if.COLOUR) != hc) bad++;
                held_v = 0;
            end
            if (draw_if.PLOT && draw_if.DRAW_READY) begin
                b  = b0 + k / NPIX;
                p  = k % NPIX;
                ex = AX + (b % COLS) * PX + p % BW;
                ey = AY + (b / COLS) * PY + p / BW;
                ec = exp_colour(mh[b]);
                if (int'(draw_if.XOUT) != ex || int'(draw_if.YOUT) != ey ||
                    int'(draw_if.COLOUR) != ec) bad++;
                if (k == 0) begin
                    first_x = int'(draw_if.XOUT); first_y = int'(draw_if.YOUT);
                    first_c = int'(draw_if.COLOUR);
                end
                last_x = int'(draw_if.XOUT); last_y = int'(draw_if.YOUT);
                last_c = int'(draw_if.COLOUR);
                k++;
            end else if (draw_if.PLOT) begin
                hx = int'(draw_if.XOUT); hy = int'(draw_if.YOUT);
                hc = int'(draw_if.COLOUR); held_v = 1;
            end
            @(negedge clk);
            cyc++;
        end
        draw_if.DRAW_READY = 1'b1;
        check("pixel_count", k, total);
        check("pixel_errors", bad, 0);
        check("plot_after_draw", int'(draw_if.PLOT), 0);
    endtask

    // Issue one query from IDLE, compare against the model, follow any redraw.
    task automatic query(input int x, input int y, input bit toggle, input bit spur,
                         output int got_hit, output int lat);
        int exp_idx, plot_seen;
        plot_seen = 0;
        got_hit   = -1;
        exp_idx   = model_find(x, y);
        check("busy_before_req", int'(busy), 0);
        ball_x  = CW'(x);
        ball_y  = CW'(y);
        hit_req = 1'b1;
        lat     = 0;
        while (lat < N + 10) begin
            @(negedge clk);
            lat++;
            hit_req = 1'b0;
            if (lat == 1) check("busy_after_req", int'(busy), 1);
            if (hit_done) break;
            if (draw_if.PLOT) plot_seen++;
            if (spur && lat == 3) begin
                ball_x  = CW'($urandom_range(0, 165));
                ball_y  = CW'($urandom_range(0, 55));
                hit_req = 1'b1;
            end
        end
        check("hit_done_seen", int'(hit_done), 1);
        got_hit = int'(hit);
        check("hit", got_hit, (exp_idx >= 0) ? 1 : 0);
        check("latency", lat, (exp_idx >= 0) ? exp_idx + 2 : N + 1);
        check("plot_during_check", plot_seen, 0);
        if (exp_idx >= 0) begin
            mh[exp_idx]--;
            if (mh[exp_idx] == 0) begin
                m_left--;
                if (m_left == 0) m_clear = 1;
            end
            collect(exp_idx, 1, toggle);
        end else begin
            check("plot_after_miss", int'(draw_if.PLOT), 0);
        end
        check("busy_idle", int'(busy), 0);
        @(negedge clk);
        check("done_single_pulse", int'(hit_done), 0);
        check("busy_no_queue", int'(busy), 0);
        check("bricks_left", int'(bricks_left), m_left);
        check("level_clear", int'(level_clear), m_clear);
    endtask

    task automatic check_reset_values();
        check("rst_busy", int'(busy), 1);
        check("rst_plot", int'(draw_if.PLOT), 0);
        check("rst_xout", int'(draw_if.XOUT), 0);
        check("rst_yout", int'(draw_if.YOUT), 0);
        check("rst_colour", int'(draw_if.COLOUR), 0);
        check("rst_hit_done", int'(hit_done), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_left", int'(bricks_left), 0);
        check("rst_clear", int'(level_clear), 0);
    endtask

    task automatic check_full_draw();
        model_reload();
        collect(0, N, 1'b0);
        check("first_px_x", first_x, 2);
        check("first_px_y", first_y, 4);
        check("first_px_c", first_c, 4);
        check("last_px_x", last_x, 157);
        check("last_px_y", last_y, 47);
        check("last_px_c", last_c, 6);
        check("busy_after_full", int'(busy), 0);
        check("left_after_full", int'(bricks_left), N);
        check("clear_after_full", int'(level_clear), 0);
    endtask

    initial begin
        int got_hit, lat, x, y, b, guard, done_seen;

        vecs[0]  = '{3,   5,  1, 0,  1, 32, 1'b0};
        vecs[1]  = '{18,  5,  0, 0,  0, 32, 1'b0};
        vecs[2]  = '{3,   41, 1, 24, 7, 31, 1'b0};
        vecs[3]  = '{3,   41, 0, 0,  0, 31, 1'b0};
        vecs[4]  = '{17,  11, 1, 0,  2, 31, 1'b0};
        vecs[5]  = '{22,  4,  1, 1,  1, 31, 1'b0};
        vecs[6]  = '{2,   12, 0, 0,  0, 31, 1'b0};
        vecs[7]  = '{1,   4,  0, 0,  0, 31, 1'b0};
        vecs[8]  = '{157, 47, 1, 31, 7, 30, 1'b0};
        vecs[9]  = '{158, 47, 0, 0,  0, 30, 1'b0};
        vecs[10] = '{45,  8,  1, 2,  1, 30, 1'b1};
        vecs[11] = '{45,  16, 1, 10, 2, 30, 1'b0};

        draw_if.DRAW_READY = 1'b1;
        #3;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        check_full_draw();

        foreach (vecs[i]) begin
            query(vecs[i].x, vecs[i].y, vecs[i].toggle, 1'b0, got_hit, lat);
            check("vec_hit", got_hit, vecs[i].exp_hit);
            check("vec_latency", lat, vecs[i].exp_hit ? vecs[i].exp_idx + 2 : N + 1);
            if (vecs[i].exp_hit != 0) check("vec_colour", last_c, vecs[i].exp_colour);
            check("vec_left", int'(bricks_left), vecs[i].exp_left);
        end

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                b = int'($urandom_range(0, N - 1));
                x = AX + (b % COLS) * PX + int'($urandom_range(0, BW - 1));
                y = AY + (b / COLS) * PY + int'($urandom_range(0, BH - 1));
            end else begin
                x = int'($urandom_range(0, 165));
                y = int'($urandom_range(0, 55));
            end
            query(x, y, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, got_hit, lat);
        end

        for (int i = 0; i < N; i++) begin
            guard = 0;
            while (mh[i] > 0 && guard < 10) begin
                query(AX + (i % COLS) * PX + 3, AY + (i / COLS) * PY + 2, 1'b0, 1'b0, got_hit, lat);
                guard++;
            end
        end
        check("final_left", int'(bricks_left), 0);
        check("final_clear", int'(level_clear), 1);

        // Abort a CHECK over an empty field; no HIT_DONE may follow.
        ball_x = CW'(3); ball_y = CW'(5); hit_req = 1'b1;
        @(negedge clk); hit_req = 1'b0;
        repeat (4) @(negedge clk);
        level_load = 1'b1;
        draw_if.DRAW_READY = 1'b0;
        @(negedge clk); level_load = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (hit_done) done_seen++;
            @(negedge clk);
        end
        check("no_done_after_abort", done_seen, 0);
        check_full_draw();

        // LEVEL_LOAD part-way through a redraw.
        ball_x = CW'(3); ball_y = CW'(5); hit_req = 1'b1;
        @(negedge clk); hit_req = 1'b0;
        guard = 0;
        while (!hit_done && guard < 50) begin @(negedge clk); guard++; end
        check("redraw_hit", int'(hit), 1);
        repeat (20) @(negedge clk);
        check("plot_mid_redraw", int'(draw_if.PLOT), 1);
        level_load = 1'b1;
        @(negedge clk); level_load = 1'b0;
        check_full_draw();

        // RESETN pulse part-way through a full draw.
        level_load = 1'b1;
        @(negedge clk); level_load = 1'b0;
        repeat (300) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        check_full_draw();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
